// File: rtl/mdclcg_pkg.sv
// Shared MDCLCG definitions: collector FSM states and integration defaults.
package mdclcg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    COLLECT = 2'd2
  } state_t;

  localparam int MDCLCG_WORD_W  = 32;
  localparam int MDCLCG_DISCARD = 16;
  localparam int MDCLCG_DEPTH   = 4;
  localparam int MDCLCG_OVF_W   = 16;

endpackage

// File: rtl/mdclcg_word_collector_if.sv
// Word-stream handshake between the collector (master) and its consumer (slave).
interface mdclcg_word_collector_if
  import mdclcg_pkg::*;
#(
  parameter int WORD_W = MDCLCG_WORD_W
);

  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready;

  modport master (
    output word_out,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_out,
    input  word_valid,
    output word_ready
  );

endinterface

// File: rtl/mdclcg_word_fifo.sv
// DEPTH x WORD_W synchronous FIFO; head word registered, no fall-through.
// A push while full is accepted only when a pop happens in the same cycle.
module mdclcg_word_fifo #(
  parameter  int WORD_W = 32,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [WORD_W-1:0] push_dat_i,
  input  logic              pop_i,
  output logic [WORD_W-1:0] head_dat_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q;
  logic [PTR_W-1:0]  rd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              do_push;
  logic              do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;

  // Pop is evaluated against the pre-push occupancy, so an empty FIFO never pops.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        wr_q <= wr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= push_dat_i;
    end
  end

  assign head_dat_o = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/mdclcg_word_collector.sv
// Drops DISCARD warm-up bits, packs the zi stream LSB-first into WORD_W words, buffers them in a FIFO.
// Words arriving at a full FIFO with no pop are dropped and counted in a saturating counter.
module mdclcg_word_collector
  import mdclcg_pkg::*;
#(
  parameter int WORD_W  = MDCLCG_WORD_W,
  parameter int DISCARD = MDCLCG_DISCARD,
  parameter int DEPTH   = MDCLCG_DEPTH,
  parameter int OVF_W   = MDCLCG_OVF_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  mdclcg_word_collector_if.master wif,
  output logic [OVF_W-1:0]        overflow_cnt,
  output logic                    busy
);

  localparam int                IDX_W    = $clog2(WORD_W);
  localparam int                DC_W     = (DISCARD > 1) ? $clog2(DISCARD) : 1;
  localparam int                CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WORD_W - 1);
  localparam logic [DC_W-1:0]   DC_LAST  = DC_W'((DISCARD > 0) ? DISCARD - 1 : 0);
  localparam logic [OVF_W-1:0]  OVF_MAX  = '1;

  state_t            state_q;
  logic              busy_q;
  logic [DC_W-1:0]   disc_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] shift_d;
  logic [OVF_W-1:0]  ovf_q;

  logic              take_bit;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [WORD_W-1:0] fifo_head;

  assign take_bit = (state_q == COLLECT) && enable && bit_valid;
  assign push     = take_bit && (idx_q == IDX_LAST);
  assign pop      = wif.word_ready && !fifo_empty;

  // The completing bit is merged combinationally so the word is pushed on the same edge.
  always_comb begin
    shift_d        = shift_q;
    shift_d[idx_q] = bit_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      disc_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          disc_q  <= '0;
          idx_q   <= '0;
          shift_q <= '0;
          if (enable) begin
            state_q <= (DISCARD > 0) ? WARMUP : COLLECT;
            busy_q  <= 1'b1;
          end
        end
        WARMUP: begin
          if (!enable) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            disc_q  <= '0;
          end else if (bit_valid) begin
            if (disc_q == DC_LAST) begin
              state_q <= COLLECT;
              disc_q  <= '0;
            end else begin
              disc_q <= disc_q + DC_W'(1);
            end
          end
        end
        COLLECT: begin
          if (!enable) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            idx_q   <= '0;
            shift_q <= '0;
          end else if (bit_valid) begin
            shift_q <= shift_d;
            idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= '0;
    end else if (push && fifo_full && !pop && (ovf_q != OVF_MAX)) begin
      ovf_q <= ovf_q + OVF_W'(1);
    end
  end

  mdclcg_word_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_dat_i (shift_d),
    .pop_i      (pop),
    .head_dat_o (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt)
  );

  assign wif.word_out   = fifo_head;
  assign wif.word_valid = !fifo_empty;
  assign overflow_cnt   = ovf_q;
  assign busy           = busy_q;

  a_cnt_bound : assert property (@(posedge clk) disable iff (reset)
    fifo_cnt <= CNT_W'(DEPTH));
  a_full_nonempty : assert property (@(posedge clk) disable iff (reset)
    !(fifo_full && fifo_empty));

endmodule

// File: doc/mdclcg_word_collector.md
Name: mdclcg_word_collector

Overview:
- Receiving end of the MDCLCG serial random-bit stream (zi).
- Discards a configurable warm-up run of bits, then packs the stream into WORD_W-bit words.
- Buffers completed words in a small FIFO with a valid/ready interface to the downstream consumer (key-stream buffer, statistics engine).
- Counts words lost when the consumer stalls.

Parameters:
- WORD_W, 32, packed word width in bits (2..64).
- DISCARD, 16, number of valid bits dropped after enable before packing starts (0 allowed).
- DEPTH, 4, FIFO depth in words (power of two, at least 2).
- OVF_W, 16, width of the overflow counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  collection enable; level-sensitive.
- bit_in  input  1  serial bit from generator (zi).
- bit_valid  input  1  bit_in is sampled on this cycle.
- word_out  output  WORD_W  FIFO head word.
- word_valid  output  1  FIFO non-empty.
- word_ready  input  1  consumer accepts head word when word_valid is high.
- overflow_cnt  output  OVF_W  count of dropped words; saturating.
- busy  output  1  high in WARMUP or COLLECT.

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted:
  - state = IDLE;
  - FIFO empty: word_valid=0, word_out=0;
  - overflow_cnt=0, busy=0;
  - bit counter and shift register cleared.
- State IDLE:
  - enable=1 goes to WARMUP if DISCARD>0, otherwise directly to COLLECT.
  - bit_valid is ignored.
- State WARMUP:
  - Each cycle with bit_valid=1 increments the discard counter.
  - On the DISCARD-th valid bit, go to COLLECT. That bit is discarded, not packed.
- State COLLECT:
  - Each valid bit is written to shift-register position idx, where idx runs 0..WORD_W-1.
  - The first packed bit lands in word bit 0 (LSB-first).
  - On the WORD_W-th bit, the completed word, including that bit, is pushed to the FIFO in the same clock edge. idx wraps to 0 and collection continues with no bubble.
  - Back-to-back words are supported with bit_valid held high every cycle.
- Latency: word_valid rises on the clock edge that samples the final bit of the first word. It is visible in the cycle after that bit is presented.
- enable deasserted in WARMUP or COLLECT:
  - return to IDLE on the next edge;
  - the partial word and the discard count are dropped;
  - FIFO contents and overflow_cnt are preserved.
  - Re-enabling restarts warm-up from zero.
- Handshake:
  - A pop occurs when word_valid and word_ready are both high.
  - word_out is stable while word_valid=1 and no pop occurs.
  - word_ready while empty has no effect.
- FIFO full and push:
  - if a pop occurs in the same cycle, the push is accepted and the occupancy is unchanged;
  - otherwise the new word is dropped, the FIFO is unchanged, and overflow_cnt increments.
- overflow_cnt saturates at 2^OVF_W-1; it does not wrap.
- Empty FIFO with push and word_ready=1 in the same cycle: no pop. The word appears the next cycle (no fall-through).
- Occupancy counter width is clog2(DEPTH)+1. Read and write pointers wrap modulo DEPTH.
- Reset asserted mid-word: all state is cleared immediately, including buffered words.

Decomposition:
- Shared package mdclcg_pkg:
  - state enum {IDLE, WARMUP, COLLECT};
  - default WORD_W, DISCARD, DEPTH constants, also used by the MDCLCG top-level integration.
- One sub-module: mdclcg_word_fifo, a synchronous DEPTH x WORD_W FIFO with push/pop, full/empty and count outputs.
  - The collector owns the FSM, the shift register and the overflow logic.

Test Plan:
- Warm-up discard: WORD_W=8, DISCARD=4, enable=1, bits 1,1,1,1 then 1,0,1,1,0,0,1,0 → first word = 8'h4D; word_valid rises exactly 1 cycle after the 12th valid bit.
- Back-to-back with gaps: bit_valid continuous for 32 bits, then toggled 50% for 32 bits, word_ready=1 → two 32-bit words match the reference-model packing; no loss; overflow_cnt=0.
- Overflow: DEPTH=4, word_ready=0, push 6 words → FIFO holds words 1–4, overflow_cnt=2. Then drain with word_ready=1 → words 1–4 in order, then word_valid=0.
- Full with simultaneous pop: FIFO full, word_ready=1 in the same cycle as a push → push accepted, count stays 4, overflow_cnt unchanged.
- Enable drop mid-word: 5 of 8 bits collected, then enable=0 for 1 cycle, then re-enable → partial bits discarded; warm-up repeats (DISCARD bits dropped); next word built only from fresh bits.
- Async reset: assert reset between clock edges with 3 words buffered → word_valid, busy and overflow_cnt go to 0 immediately, without waiting for clk.
